// File: rtl/post_adder_acc_if.sv
// Operand/result bundle between the operand muxes, the post-adder stage and
// the consumers of P. The master side drives operands and controls; the
// slave (post_adder_acc) returns P, carry-out, valid and the overflow flag.
interface post_adder_acc_if #(
  parameter int WIDTH = 48
);
  logic             ce_p;
  logic             in_valid;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] z;
  logic             sub;
  logic             carry_in;
  logic             clr_ovf;
  logic [WIDTH-1:0] p;
  logic             carry_out;
  logic             out_valid;
  logic             ovf;

  modport master (
    output ce_p, in_valid, x, z, sub, carry_in, clr_ovf,
    input  p, carry_out, out_valid, ovf
  );

  modport slave (
    input  ce_p, in_valid, x, z, sub, carry_in, clr_ovf,
    output p, carry_out, out_valid, ovf
  );
endinterface

// File: rtl/post_adder_acc.sv
// Post-adder/subtractor and P register stage of the DSP48A1-style slice.
// Forms z +/- (x + carry_in) at WIDTH+1 bits, optionally registers P and
// the carry-out, and keeps a sticky signed-overflow flag. P is fed back
// to the Z mux by the surrounding datapath to build an accumulator.
module post_adder_acc #(
  parameter int WIDTH       = 48,
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  post_adder_acc_if.slave bus
);

  // Signed overflow of the WIDTH-bit result. For add, operands of equal sign
  // whose result flips sign overflow; for subtract, operands of opposite sign
  // whose result sign departs from z overflow. carry_in enters only through
  // the result sign bit.
  function automatic logic ovf_detect(
    input logic sub_i,
    input logic z_sign,
    input logic x_sign,
    input logic p_sign
  );
    logic res;
    if (sub_i) begin
      res = (z_sign != x_sign) && (p_sign != z_sign);
    end else begin
      res = (z_sign == x_sign) && (p_sign != z_sign);
    end
    return res;
  endfunction

  logic [WIDTH:0]   x_ext_s;
  logic [WIDTH:0]   z_ext_s;
  logic [WIDTH:0]   cin_ext_s;
  logic [WIDTH:0]   r_s;
  logic [WIDTH-1:0] p_next_s;
  logic             cout_next_s;
  logic             ovf_cond_s;
  logic             acc_s;
  logic             ovf_r;

  // Zero-extended add/subtract at WIDTH+1 bits; subtract wraps modulo 2^(WIDTH+1)
  // so the top bit doubles as the borrow indicator.
  always_comb begin
    x_ext_s   = {1'b0, bus.x};
    z_ext_s   = {1'b0, bus.z};
    cin_ext_s = {{WIDTH{1'b0}}, bus.carry_in};
    if (bus.sub) begin
      r_s = z_ext_s - (x_ext_s + cin_ext_s);
    end else begin
      r_s = z_ext_s + x_ext_s + cin_ext_s;
    end
  end

  assign p_next_s    = r_s[WIDTH-1:0];
  assign cout_next_s = r_s[WIDTH];
  assign acc_s       = bus.in_valid & bus.ce_p;
  assign ovf_cond_s  = ovf_detect(bus.sub, bus.z[WIDTH-1], bus.x[WIDTH-1],
                                  p_next_s[WIDTH-1]);

  generate
    if (PREG != 0) begin : g_preg
      logic [WIDTH-1:0] p_r;
      logic             valid_r;

      // P and its valid flag load together on ce_p; idle cycles still load p_next.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p_r     <= {WIDTH{1'b0}};
          valid_r <= 1'b0;
        end else if (bus.ce_p) begin
          p_r     <= p_next_s;
          valid_r <= bus.in_valid;
        end else begin
          p_r     <= p_r;
          valid_r <= valid_r;
        end
      end

      assign bus.p         = p_r;
      assign bus.out_valid = valid_r;
    end else begin : g_pcomb
      assign bus.p         = p_next_s;
      assign bus.out_valid = bus.in_valid;
    end
  endgenerate

  generate
    if (CARRYOUTREG != 0) begin : g_coutreg
      logic cout_r;

      // Carry-out follows the same ce_p timing as the P register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cout_r <= 1'b0;
        end else if (bus.ce_p) begin
          cout_r <= cout_next_s;
        end else begin
          cout_r <= cout_r;
        end
      end

      assign bus.carry_out = cout_r;
    end else begin : g_coutcomb
      assign bus.carry_out = cout_next_s;
    end
  endgenerate

  // Sticky overflow: an accepted overflowing operation sets it and takes
  // priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (acc_s && ovf_cond_s) begin
      ovf_r <= 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign bus.ovf = ovf_r;

endmodule

// File: tb/tb_post_adder_acc.sv
// Directed bench for post_adder_acc: a PREG=1/CARRYOUTREG=1 instance driven
// from a vector table, plus a PREG=0/CARRYOUTREG=0 instance for the
// combinational path, accumulate loops and asynchronous reset sequences.
module tb_post_adder_acc;

  localparam int W = 48;

  logic clk;
  logic rst_n;

  post_adder_acc_if #(.WIDTH(W)) bus1 ();
  post_adder_acc_if #(.WIDTH(W)) bus0 ();

  post_adder_acc #(.WIDTH(W), .PREG(1), .CARRYOUTREG(1)) dut_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  post_adder_acc #(.WIDTH(W), .PREG(0), .CARRYOUTREG(0)) dut_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] z;
    logic         sub;
    logic         cin;
    logic         iv;
    logic         ce;
    logic         clr;
    logic [W-1:0] ep;
    logic         ec;
    logic         ev;
    logic         eo;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vec [NVEC];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive1(input vec_t v);
    bus1.x = v.x; bus1.z = v.z; bus1.sub = v.sub; bus1.carry_in = v.cin;
    bus1.in_valid = v.iv; bus1.ce_p = v.ce; bus1.clr_ovf = v.clr;
  endtask

  task automatic idle0();
    bus0.x = '0; bus0.z = '0; bus0.sub = 1'b0; bus0.carry_in = 1'b0;
    bus0.in_valid = 1'b0; bus0.ce_p = 1'b1; bus0.clr_ovf = 1'b0;
  endtask

  logic [W-1:0] acc_model;

  initial begin
    // vector table: operands, controls, expected state one edge later
    vec[0]  = '{48'h1,              48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 48'h0,              1'b1, 1'b1, 1'b0};
    vec[1]  = '{48'h7,              48'h5,              1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 48'hFFFF_FFFF_FFFD, 1'b1, 1'b1, 1'b0};
    vec[2]  = '{48'h20,             48'h10,             1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 48'h31,             1'b0, 1'b1, 1'b0};
    vec[3]  = '{48'h10,             48'h100,            1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 48'hF0,             1'b0, 1'b1, 1'b0};
    vec[4]  = '{48'h1,              48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 48'h8000_0000_0000, 1'b0, 1'b1, 1'b1};
    vec[5]  = '{48'h1,              48'h1,              1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 48'h2,              1'b0, 1'b1, 1'b1};
    vec[6]  = '{48'h3,              48'h2,              1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 48'h5,              1'b0, 1'b1, 1'b1};
    vec[7]  = '{48'h0,              48'h100,            1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 48'h101,            1'b0, 1'b1, 1'b1};
    vec[8]  = '{48'h1,              48'h8000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1};
    vec[9]  = '{48'h0,              48'h0,              1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 48'h0,              1'b0, 1'b0, 1'b0};
    vec[10] = '{48'h0,              48'h10,             1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 48'h10,             1'b0, 1'b1, 1'b0};
    vec[11] = '{48'h1,              48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 48'h10,             1'b0, 1'b1, 1'b0};
    vec[12] = '{48'h5,              48'hFFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 48'h10,             1'b0, 1'b1, 1'b0};
    vec[13] = '{48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 48'h10,             1'b0, 1'b1, 1'b0};
    vec[14] = '{48'h4,              48'h3,              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 48'h7,              1'b0, 1'b0, 1'b0};
    vec[15] = '{48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 48'h0,              1'b1, 1'b1, 1'b1};
    vec[16] = '{48'h0,              48'h0,              1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 48'h0,              1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    bus1.x = '0; bus1.z = '0; bus1.sub = 1'b0; bus1.carry_in = 1'b0;
    bus1.in_valid = 1'b0; bus1.ce_p = 1'b0; bus1.clr_ovf = 1'b0;
    idle0();

    #3;
    check("reset_p",     bus1.p, '0);
    check("reset_cout",  {47'b0, bus1.carry_out}, '0);
    check("reset_valid", {47'b0, bus1.out_valid}, '0);
    check("reset_ovf",   {47'b0, bus1.ovf}, '0);
    #4 rst_n = 1'b1;

    @(posedge clk); #1;

    // table-driven pass on the registered instance
    for (int i = 0; i < NVEC; i++) begin
      drive1(vec[i]);
      @(posedge clk); #1;
      check($sformatf("vec%0d_p", i),     bus1.p, vec[i].ep);
      check($sformatf("vec%0d_cout", i),  {47'b0, bus1.carry_out}, {47'b0, vec[i].ec});
      check($sformatf("vec%0d_valid", i), {47'b0, bus1.out_valid}, {47'b0, vec[i].ev});
      check($sformatf("vec%0d_ovf", i),   {47'b0, bus1.ovf}, {47'b0, vec[i].eo});
    end
    bus1.in_valid = 1'b0; bus1.clr_ovf = 1'b0;

    // combinational instance: p = z + 3 in the same cycle
    acc_model = '0;
    for (int i = 0; i < 4; i++) begin
      bus0.z = acc_model; bus0.x = 48'h3; bus0.in_valid = 1'b1; bus0.ce_p = 1'b1;
      #1;
      check($sformatf("comb_acc%0d_p", i), bus0.p, acc_model + 48'h3);
      check($sformatf("comb_acc%0d_valid", i), {47'b0, bus0.out_valid}, 48'h1);
      check($sformatf("comb_acc%0d_cout", i), {47'b0, bus0.carry_out}, '0);
      @(posedge clk); #1;
      acc_model = acc_model + 48'h3;
    end
    bus0.z = 48'h7FFF_FFFF_FFFF; bus0.x = 48'h1;
    #1;
    check("comb_ovf_p", bus0.p, 48'h8000_0000_0000);
    check("comb_ovf_before_edge", {47'b0, bus0.ovf}, '0);
    @(posedge clk); #1;
    check("comb_ovf_after_edge", {47'b0, bus0.ovf}, 48'h1);
    bus0.z = 48'hFFFF_FFFF_FFFF; bus0.x = 48'h1;
    #1;
    check("comb_wrap_p", bus0.p, '0);
    check("comb_wrap_cout", {47'b0, bus0.carry_out}, 48'h1);
    idle0();

    // registered accumulate from reset: z fed back from p
    @(posedge clk); #4 rst_n = 1'b0; #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) begin
      bus1.z = bus1.p; bus1.x = 48'h3; bus1.sub = 1'b0; bus1.carry_in = 1'b0;
      bus1.in_valid = 1'b1; bus1.ce_p = 1'b1; bus1.clr_ovf = 1'b0;
      @(posedge clk); #1;
      check($sformatf("reg_acc%0d_p", i), bus1.p, 48'(3 * i));
      check($sformatf("reg_acc%0d_valid", i), {47'b0, bus1.out_valid}, 48'h1);
    end

    // mid-accumulation asynchronous reset with random operands applied
    bus1.z = {16'($urandom), 32'($urandom)}; bus1.x = {16'($urandom), 32'($urandom)};
    bus1.sub = 1'($urandom); bus1.carry_in = 1'($urandom);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_p",     bus1.p, '0);
    check("midrst_cout",  {47'b0, bus1.carry_out}, '0);
    check("midrst_valid", {47'b0, bus1.out_valid}, '0);
    check("midrst_ovf",   {47'b0, bus1.ovf}, '0);
    check("midrst_ovf_comb", {47'b0, bus0.ovf}, '0);
    #2 rst_n = 1'b1;
    bus1.z = bus1.p; bus1.x = 48'h3; bus1.sub = 1'b0; bus1.carry_in = 1'b0;
    bus1.in_valid = 1'b1; bus1.ce_p = 1'b1;
    @(posedge clk); #1;
    check("postrst_p", bus1.p, 48'h3);
    check("postrst_valid", {47'b0, bus1.out_valid}, 48'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
